// File: rtl/mlp_stream_framer.sv
// ============================================================================
// mlp_stream_framer
// Host-link frame parser feeding the MLP controller; checks checksums and
// returns the inference result to the host.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mlp_stream_framer #(
    parameter int unsigned LOAD_BYTES  = 282620,
    parameter int unsigned IMAGE_BYTES = 784,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [19:0] TIMEOUT     = 20'hFFFFF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [1:0] mode,
    output logic [7:0] incoming_data,
    output logic       incoming_data_valid,
    input  logic [3:0] result_data_in,
    input  logic       result_data_valid_in,
    output logic [3:0] result_class,
    output logic       result_valid,
    output logic       busy,
    output logic       err_checksum,
    output logic       err_cmd,
    output logic       err_timeout
);

    localparam logic [2:0] S_HUNT     = 3'd0;
    localparam logic [2:0] S_CMD      = 3'd1;
    localparam logic [2:0] S_MODE     = 3'd2;
    localparam logic [2:0] S_GAP      = 3'd3;
    localparam logic [2:0] S_STREAM   = 3'd4;
    localparam logic [2:0] S_CHK      = 3'd5;
    localparam logic [2:0] S_WAIT_RES = 3'd6;

    localparam logic [7:0]  CMD_LOAD  = 8'h01;
    localparam logic [7:0]  CMD_INFER = 8'h02;
    localparam logic [18:0] LEN_LOAD  = 19'(LOAD_BYTES);
    localparam logic [18:0] LEN_IMAGE = 19'(IMAGE_BYTES);
    localparam logic [19:0] TMO_LAST  = TIMEOUT - 20'd1;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic        cmd_infer;
    logic [18:0] len;
    logic [7:0]  csum;
    logic [19:0] tcnt;
    logic        xfer;
    logic        cmd_ok;
    logic        timed_out;

    assign xfer      = s_valid & s_ready;
    assign cmd_ok    = (s_data == CMD_LOAD) || (s_data == CMD_INFER);
    assign timed_out = (tcnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_HUNT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_HUNT:     if (xfer && s_data == SYNC_BYTE) next_state = S_CMD;
            S_CMD:      if (xfer) next_state = cmd_ok ? S_MODE : S_HUNT;
            S_MODE:     next_state = S_GAP;
            S_GAP:      next_state = S_STREAM;
            S_STREAM:   if (xfer && len == 19'd1) next_state = S_CHK;
            S_CHK:      if (xfer) next_state = cmd_infer ? S_WAIT_RES : S_HUNT;
            S_WAIT_RES: if (result_data_valid_in || timed_out) next_state = S_HUNT;
            default:    next_state = S_HUNT;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        mode    = 2'd0;
        busy    = (state != S_HUNT);
        case (state)
            S_HUNT, S_CMD, S_STREAM, S_CHK: s_ready = 1'b1;
            S_MODE:  mode = cmd_infer ? 2'd2 : 2'd1;
            default: s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_infer           <= 1'b0;
            len                 <= '0;
            csum                <= '0;
            tcnt                <= '0;
            incoming_data       <= '0;
            incoming_data_valid <= 1'b0;
            result_class        <= '0;
            result_valid        <= 1'b0;
            err_checksum        <= 1'b0;
            err_cmd             <= 1'b0;
            err_timeout         <= 1'b0;
        end else begin
            incoming_data_valid <= 1'b0;
            result_valid        <= 1'b0;
            case (state)
                S_HUNT: begin
                    csum <= '0;
                    tcnt <= '0;
                    if (xfer && s_data == SYNC_BYTE) begin
                        err_checksum <= 1'b0;
                        err_cmd      <= 1'b0;
                        err_timeout  <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (xfer) begin
                        if (cmd_ok) begin
                            cmd_infer <= (s_data == CMD_INFER);
                            len       <= (s_data == CMD_INFER) ? LEN_IMAGE : LEN_LOAD;
                        end else begin
                            err_cmd <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        incoming_data       <= s_data;
                        incoming_data_valid <= 1'b1;
                        csum                <= csum + s_data;
                        len                 <= len - 19'd1;
                    end
                end
                S_CHK: begin
                    // Payload is already forwarded; a bad sum only flags.
                    if (xfer && (csum + s_data) != 8'd0) err_checksum <= 1'b1;
                end
                S_WAIT_RES: begin
                    tcnt <= tcnt + 20'd1;
                    if (result_data_valid_in) begin
                        result_class <= result_data_in;
                        result_valid <= 1'b1;
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mlp_stream_framer.sv
// ============================================================================
// tb_mlp_stream_framer
// Scoreboard bench for mlp_stream_framer with small frame sizes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mlp_stream_framer;

    localparam int          N_LOAD  = 4;
    localparam int          N_IMAGE = 3;
    localparam logic [19:0] TMO     = 20'd16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [1:0] mode;
    logic [7:0] incoming_data;
    logic       incoming_data_valid;
    logic [3:0] result_data_in = 4'd0;
    logic       result_data_valid_in = 1'b0;
    logic [3:0] result_class;
    logic       result_valid;
    logic       busy;
    logic       err_checksum;
    logic       err_cmd;
    logic       err_timeout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int strobes = 0;
    int mode_cycles = 0;
    int res_pulses = 0;
    logic [1:0] last_mode = 2'd0;
    logic [7:0] exp_data[$];
    int         exp_cyc[$];

    mlp_stream_framer #(
        .LOAD_BYTES (N_LOAD),
        .IMAGE_BYTES(N_IMAGE),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT    (TMO)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .s_data              (s_data),
        .s_valid             (s_valid),
        .s_ready             (s_ready),
        .mode                (mode),
        .incoming_data       (incoming_data),
        .incoming_data_valid (incoming_data_valid),
        .result_data_in      (result_data_in),
        .result_data_valid_in(result_data_valid_in),
        .result_class        (result_class),
        .result_valid        (result_valid),
        .busy                (busy),
        .err_checksum        (err_checksum),
        .err_cmd             (err_cmd),
        .err_timeout         (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Payload strobes are matched against bytes in acceptance order and must
    // arrive exactly one cycle after the accepting edge.
    always @(negedge clk) begin
        if (incoming_data_valid) begin
            strobes++;
            checks++;
            if (exp_data.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got strobe data=%h, required no strobe", incoming_data);
            end else begin
                logic [7:0] d;
                int         c;
                d = exp_data.pop_front();
                c = exp_cyc.pop_front();
                if (incoming_data !== d || cyc != c + 1) begin
                    errors++;
                    $display("FAIL stream_byte: got %h at cycle %0d, required %h at cycle %0d",
                             incoming_data, cyc, d, c + 1);
                end
            end
        end
        if (mode != 2'd0) begin
            mode_cycles++;
            last_mode = mode;
        end
        if (result_valid) res_pulses++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        strobes     = 0;
        mode_cycles = 0;
        res_pulses  = 0;
        last_mode   = 2'd0;
    endtask

    task automatic send(input logic [7:0] b, input bit payload);
        int n = 0;
        @(negedge clk);
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL send_ready: s_ready=0 after %0d cycles, required 1", n);
            s_valid = 1'b0;
            return;
        end
        if (payload) begin
            exp_data.push_back(b);
            exp_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
    endtask

    // Payload byte i is base*(i+1); CHK makes the sum zero, then chk_err is added.
    task automatic send_frame(input logic [7:0] cmd, input int n, input logic [7:0] base,
                              input logic [7:0] chk_err, input bit gaps);
        logic [7:0] sum = 8'd0;
        logic [7:0] b;
        send(8'hA5, 1'b0);
        send(cmd, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = base * 8'(i + 1);
            sum = sum + b;
            send(b, 1'b1);
            if (gaps) @(negedge clk);
        end
        send(8'(8'd0 - sum) + chk_err, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, mode, incoming_data_valid, result_valid, result_class, busy,
             err_checksum, err_cmd, err_timeout} !== {1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: ready=%b mode=%0d dv=%b rv=%b cls=%0d busy=%b err=%b%b%b, required ready=1 rest 0",
                     s_ready, mode, incoming_data_valid, result_valid, result_class, busy,
                     err_checksum, err_cmd, err_timeout);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        clear_counts();
        send_frame(8'h01, N_LOAD, 8'h10, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (mode_cycles != 1 || last_mode !== 2'd1) begin
            errors++;
            $display("FAIL load_mode: cycles=%0d mode=%0d, required 1 cycle of mode 1", mode_cycles, last_mode);
        end
        checks++;
        if (strobes != N_LOAD || exp_data.size() != 0) begin
            errors++;
            $display("FAIL load_strobes: got %0d pending %0d, required %0d pending 0", strobes, exp_data.size(), N_LOAD);
        end
        checks++;
        if (err_checksum !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_end: err_checksum=%b busy=%b, required 0 0", err_checksum, busy);
        end
    endtask

    task automatic test_infer();
        int bad = 0;
        clear_counts();
        send_frame(8'h02, N_IMAGE, 8'h01, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (s_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL infer_wait_ready: %0d wait cycles with s_ready=1 or busy=0, required 0", bad);
        end
        result_data_in       = 4'd7;
        result_data_valid_in = 1'b1;
        @(negedge clk);
        result_data_valid_in = 1'b0;
        checks++;
        if (result_valid !== 1'b1 || result_class !== 4'd7) begin
            errors++;
            $display("FAIL infer_result: valid=%b class=%0d, required 1 7", result_valid, result_class);
        end
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || res_pulses != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL infer_pulse: valid=%b pulses=%0d busy=%b, required 0 1 0", result_valid, res_pulses, busy);
        end
        checks++;
        if (mode_cycles != 1 || last_mode !== 2'd2 || strobes != N_IMAGE || err_checksum !== 1'b0) begin
            errors++;
            $display("FAIL infer_frame: mode_cycles=%0d mode=%0d strobes=%0d errchk=%b, required 1 2 %0d 0",
                     mode_cycles, last_mode, strobes, err_checksum, N_IMAGE);
        end
    endtask

    task automatic test_bad_checksum();
        clear_counts();
        send_frame(8'h01, N_LOAD, 8'h0B, 8'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (strobes != N_LOAD || err_checksum !== 1'b1) begin
            errors++;
            $display("FAIL badchk_flag: strobes=%0d err_checksum=%b, required %0d 1", strobes, err_checksum, N_LOAD);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err_checksum !== 1'b1) begin
            errors++;
            $display("FAIL badchk_sticky: err_checksum=%b, required 1", err_checksum);
        end
    endtask

    task automatic test_garbage_cmd();
        clear_counts();
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        checks++;
        if (busy !== 1'b0 || err_checksum !== 1'b1) begin
            errors++;
            $display("FAIL garbage_drop: busy=%b err_checksum=%b, required 0 1", busy, err_checksum);
        end
        send(8'hA5, 1'b0);
        checks++;
        if (busy !== 1'b1 || err_checksum !== 1'b0) begin
            errors++;
            $display("FAIL sync_clear: busy=%b err_checksum=%b, required 1 0", busy, err_checksum);
        end
        send(8'h03, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (err_cmd !== 1'b1 || busy !== 1'b0 || mode_cycles != 0 || strobes != 0) begin
            errors++;
            $display("FAIL bad_cmd: err_cmd=%b busy=%b mode_cycles=%0d strobes=%0d, required 1 0 0 0",
                     err_cmd, busy, mode_cycles, strobes);
        end
    endtask

    task automatic test_gaps();
        clear_counts();
        send_frame(8'h01, N_LOAD, 8'h21, 8'd0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (strobes != N_LOAD || exp_data.size() != 0 || err_cmd !== 1'b0 || err_checksum !== 1'b0) begin
            errors++;
            $display("FAIL gaps: strobes=%0d pending=%0d err_cmd=%b errchk=%b, required %0d 0 0 0",
                     strobes, exp_data.size(), err_cmd, err_checksum, N_LOAD);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        clear_counts();
        @(negedge clk);
        result_data_in       = 4'd3;
        result_data_valid_in = 1'b1;
        @(negedge clk);
        result_data_valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (res_pulses != 0 || result_class !== 4'd7) begin
            errors++;
            $display("FAIL idle_result_ignored: pulses=%0d class=%0d, required 0 7", res_pulses, result_class);
        end
        send_frame(8'h02, N_IMAGE, 8'h05, 8'd0, 1'b0);
        while (n < 40) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        checks++;
        if (n != int'(TMO) || err_timeout !== 1'b1 || res_pulses != 0) begin
            errors++;
            $display("FAIL timeout: wait_cycles=%0d err_timeout=%b pulses=%0d, required %0d 1 0",
                     n, err_timeout, res_pulses, TMO);
        end
    endtask

    task automatic test_reset_mid_stream();
        int s0;
        clear_counts();
        send(8'hA5, 1'b0);
        send(8'h01, 1'b0);
        send(8'h44, 1'b1);
        send(8'h55, 1'b1);
        reset_n = 1'b0;
        #1;
        exp_data.delete();
        exp_cyc.delete();
        s0 = strobes;
        checks++;
        if ({s_ready, mode, incoming_data_valid, result_valid, result_class, busy,
             err_checksum, err_cmd, err_timeout} !== {1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL reset_mid: ready=%b mode=%0d dv=%b rv=%b cls=%0d busy=%b err=%b%b%b, required ready=1 rest 0",
                     s_ready, mode, incoming_data_valid, result_valid, result_class, busy,
                     err_checksum, err_cmd, err_timeout);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (strobes != s0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: strobes_after_reset=%0d busy=%b, required 0 0", strobes - s0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_infer();
        test_bad_checksum();
        test_garbage_cmd();
        test_gaps();
        test_timeout();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
